// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: detects load-use and pop-use hazards, stalls or flushes
// fetch/decode around them and around PC pops, and counts stalled cycles.
module hazard_ctrl #(
  parameter int AW      = 3,
  parameter int MEM_LAT = 1,
  parameter int PC_LAT  = 2,
  parameter int R0_ZERO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs_dec,
  input  logic [AW-1:0] rd_dec,
  input  logic          use_rs_dec,
  input  logic          use_rd_dec,
  input  logic          jmp_dec,
  input  logic          mem_write_dec,
  input  logic          reg_write_dec,
  input  logic          out_dec,
  input  logic [AW-1:0] dst_ex,
  input  logic          mem_read_ex,
  input  logic          pop_ex,
  input  logic          pop_flags_ex,
  input  logic          pop_pc_ex,
  input  logic          jmp_taken_ex,
  output logic          pc_write_en,
  output logic          fd_write_en,
  output logic          bubble_sel,
  output logic          flush_fd,
  output logic          busy,
  output logic [15:0]   perf_stalls
);

  localparam int CW = $clog2(8) + 1;

  typedef enum logic [1:0] {IDLE, STALL, PCWAIT} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [15:0]   r_perf;

  logic w_m_rs;
  logic w_m_rd;
  logic w_load_use;
  logic w_pop_use;
  logic w_hazard;

  // A write to r0 is discarded when R0_ZERO is set, so it can never feed a consumer.
  assign w_m_rs = (dst_ex == rs_dec) && !((R0_ZERO != 0) && (dst_ex == '0));
  assign w_m_rd = (dst_ex == rd_dec) && !((R0_ZERO != 0) && (dst_ex == '0));

  assign w_load_use = mem_read_ex && !pop_ex &&
                      ((w_m_rs && use_rs_dec) || (w_m_rd && use_rd_dec));
  assign w_pop_use  = mem_read_ex && pop_ex && !pop_flags_ex && !pop_pc_ex &&
                      ((w_m_rd && (jmp_dec || reg_write_dec || out_dec)) ||
                       ((w_m_rs || w_m_rd) && mem_write_dec));
  assign w_hazard   = w_load_use || w_pop_use;

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    pc_write_en = 1'b1;
    fd_write_en = 1'b1;
    bubble_sel  = 1'b0;
    flush_fd    = 1'b0;
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          if (pop_pc_ex) begin
            pc_write_en = 1'b0;
            fd_write_en = 1'b0;
            flush_fd    = 1'b1;
            bubble_sel  = 1'b1;
            if (PC_LAT > 1) begin
              w_state_nxt = PCWAIT;
              w_cnt_nxt   = CW'(PC_LAT - 1);
            end
          end else if (jmp_taken_ex) begin
            flush_fd   = 1'b1;
            bubble_sel = 1'b1;
          end else if (w_hazard) begin
            pc_write_en = 1'b0;
            fd_write_en = 1'b0;
            bubble_sel  = 1'b1;
            if (MEM_LAT > 1) begin
              w_state_nxt = STALL;
              w_cnt_nxt   = CW'(MEM_LAT - 1);
            end
          end
        end
        STALL: begin
          pc_write_en = 1'b0;
          fd_write_en = 1'b0;
          bubble_sel  = 1'b1;
          w_cnt_nxt   = r_cnt - 1'b1;
          if (r_cnt <= CW'(1)) w_state_nxt = IDLE;
        end
        PCWAIT: begin
          pc_write_en = 1'b0;
          fd_write_en = 1'b0;
          flush_fd    = 1'b1;
          bubble_sel  = 1'b1;
          w_cnt_nxt   = r_cnt - 1'b1;
          if (r_cnt <= CW'(1)) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_perf  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (!pc_write_en && (r_perf != 16'hFFFF)) r_perf <= r_perf + 16'd1;
    end
  end

  assign busy        = (r_state != IDLE);
  assign perf_stalls = r_perf;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances with different latencies share one
// set of decode/ALU inputs; each step checks combinational outputs mid-cycle.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rs_dec, rd_dec, dst_ex;
  logic       use_rs_dec, use_rd_dec, jmp_dec, mem_write_dec, reg_write_dec, out_dec;
  logic       mem_read_ex, pop_ex, pop_flags_ex, pop_pc_ex, jmp_taken_ex;

  // a: MEM_LAT=3 PC_LAT=2 R0_ZERO=0; b: MEM_LAT=1 PC_LAT=2 R0_ZERO=1; c: MEM_LAT=4 PC_LAT=3
  logic        pc_a, fd_a, bub_a, fl_a, busy_a;
  logic        pc_b, fd_b, bub_b, fl_b, busy_b;
  logic        pc_c, fd_c, bub_c, fl_c, busy_c;
  logic [15:0] perf_a, perf_b, perf_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.AW(3), .MEM_LAT(3), .PC_LAT(2), .R0_ZERO(0)) u_a (
    .clk(clk), .rst(rst), .rs_dec(rs_dec), .rd_dec(rd_dec),
    .use_rs_dec(use_rs_dec), .use_rd_dec(use_rd_dec), .jmp_dec(jmp_dec),
    .mem_write_dec(mem_write_dec), .reg_write_dec(reg_write_dec), .out_dec(out_dec),
    .dst_ex(dst_ex), .mem_read_ex(mem_read_ex), .pop_ex(pop_ex),
    .pop_flags_ex(pop_flags_ex), .pop_pc_ex(pop_pc_ex), .jmp_taken_ex(jmp_taken_ex),
    .pc_write_en(pc_a), .fd_write_en(fd_a), .bubble_sel(bub_a), .flush_fd(fl_a),
    .busy(busy_a), .perf_stalls(perf_a));

  hazard_ctrl #(.AW(3), .MEM_LAT(1), .PC_LAT(2), .R0_ZERO(1)) u_b (
    .clk(clk), .rst(rst), .rs_dec(rs_dec), .rd_dec(rd_dec),
    .use_rs_dec(use_rs_dec), .use_rd_dec(use_rd_dec), .jmp_dec(jmp_dec),
    .mem_write_dec(mem_write_dec), .reg_write_dec(reg_write_dec), .out_dec(out_dec),
    .dst_ex(dst_ex), .mem_read_ex(mem_read_ex), .pop_ex(pop_ex),
    .pop_flags_ex(pop_flags_ex), .pop_pc_ex(pop_pc_ex), .jmp_taken_ex(jmp_taken_ex),
    .pc_write_en(pc_b), .fd_write_en(fd_b), .bubble_sel(bub_b), .flush_fd(fl_b),
    .busy(busy_b), .perf_stalls(perf_b));

  hazard_ctrl #(.AW(3), .MEM_LAT(4), .PC_LAT(3), .R0_ZERO(0)) u_c (
    .clk(clk), .rst(rst), .rs_dec(rs_dec), .rd_dec(rd_dec),
    .use_rs_dec(use_rs_dec), .use_rd_dec(use_rd_dec), .jmp_dec(jmp_dec),
    .mem_write_dec(mem_write_dec), .reg_write_dec(reg_write_dec), .out_dec(out_dec),
    .dst_ex(dst_ex), .mem_read_ex(mem_read_ex), .pop_ex(pop_ex),
    .pop_flags_ex(pop_flags_ex), .pop_pc_ex(pop_pc_ex), .jmp_taken_ex(jmp_taken_ex),
    .pc_write_en(pc_c), .fd_write_en(fd_c), .bubble_sel(bub_c), .flush_fd(fl_c),
    .busy(busy_c), .perf_stalls(perf_c));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rs_dec = '0; rd_dec = '0; dst_ex = '0;
    use_rs_dec = 0; use_rd_dec = 0; jmp_dec = 0; mem_write_dec = 0;
    reg_write_dec = 0; out_dec = 0; mem_read_ex = 0; pop_ex = 0;
    pop_flags_ex = 0; pop_pc_ex = 0; jmp_taken_ex = 0;
  endtask

  // Load into r2 followed by a decode instruction reading r2 through rs.
  task automatic load_hz();
    dst_ex = 3'd2; rs_dec = 3'd2; use_rs_dec = 1; mem_read_ex = 1; pop_ex = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    clr();
    tick();
    rst = 0;
  endtask

  initial begin
    // Reset holds outputs at their idle values even with a hazard on the inputs
    rst = 1;
    clr();
    load_hz();
    tick();
    check("rst_pc", pc_a, 1);
    check("rst_fd", fd_a, 1);
    check("rst_bub", bub_a, 0);
    check("rst_flush", fl_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_perf", perf_a, 0);
    clr();
    rst = 0;
    tick();
    check("idle_pc", pc_a, 1);
    check("idle_bub", bub_a, 0);
    check("idle_flush", fl_a, 0);

    // Load-use with MEM_LAT=3; pop/jump inputs during STALL are ignored
    do_reset();
    load_hz();
    #1;
    check("lu_c0_pc", pc_a, 0);
    check("lu_c0_fd", fd_a, 0);
    check("lu_c0_bub", bub_a, 1);
    check("lu_c0_flush", fl_a, 0);
    check("lu_c0_busy", busy_a, 0);
    tick();
    clr();
    pop_pc_ex = 1;
    jmp_taken_ex = 1;
    #1;
    check("lu_c1_busy", busy_a, 1);
    check("lu_c1_pc", pc_a, 0);
    check("lu_c1_flush_ignored", fl_a, 0);
    tick();
    clr();
    #1;
    check("lu_c2_busy", busy_a, 1);
    check("lu_c2_pc", pc_a, 0);
    tick();
    check("lu_c3_pc", pc_a, 1);
    check("lu_c3_bub", bub_a, 0);
    check("lu_c3_busy", busy_a, 0);
    check("lu_perf", perf_a, 3);

    // Pop-use with MEM_LAT=1
    do_reset();
    mem_read_ex = 1; pop_ex = 1; dst_ex = 3'd5; rd_dec = 3'd5; reg_write_dec = 1;
    #1;
    check("pu_pc", pc_b, 0);
    check("pu_bub", bub_b, 1);
    check("pu_busy", busy_b, 0);
    tick();
    clr();
    #1;
    check("pu_after_pc", pc_b, 1);
    check("pu_perf", perf_b, 1);
    mem_read_ex = 1; pop_ex = 1; dst_ex = 3'd5; rd_dec = 3'd5; reg_write_dec = 1;
    pop_flags_ex = 1;
    #1;
    check("pu_flags_pc", pc_b, 1);
    check("pu_flags_bub", bub_b, 0);
    pop_flags_ex = 0; reg_write_dec = 0; rd_dec = 3'd3; rs_dec = 3'd5; use_rs_dec = 1;
    #1;
    check("pu_rs_noclass_pc", pc_b, 1);
    mem_write_dec = 1;
    #1;
    check("pu_rs_memw_pc", pc_b, 0);
    tick();
    clr();

    // PC pop wins over a simultaneous load-use hazard
    do_reset();
    load_hz();
    pop_pc_ex = 1;
    #1;
    check("pp_c0_flush", fl_a, 1);
    check("pp_c0_pc", pc_a, 0);
    check("pp_c0_fd", fd_a, 0);
    check("pp_c0_bub", bub_a, 1);
    tick();
    clr();
    #1;
    check("pp_c1_flush", fl_a, 1);
    check("pp_c1_pc", pc_a, 0);
    check("pp_c1_busy", busy_a, 1);
    tick();
    check("pp_c2_flush", fl_a, 0);
    check("pp_c2_pc", pc_a, 1);
    check("pp_c2_busy", busy_a, 0);
    check("pp_perf", perf_a, 2);
    check("pp3_c2_flush", fl_c, 1);
    check("pp3_c2_busy", busy_c, 1);
    tick();
    check("pp3_c3_busy", busy_c, 0);
    check("pp3_perf", perf_c, 3);

    // Taken jump wins over a hazard: one-cycle flush, no stall
    do_reset();
    load_hz();
    jmp_taken_ex = 1;
    #1;
    check("jmp_flush", fl_a, 1);
    check("jmp_bub", bub_a, 1);
    check("jmp_pc", pc_a, 1);
    check("jmp_fd", fd_a, 1);
    check("jmp_busy", busy_a, 0);
    tick();
    clr();
    #1;
    check("jmp_after_flush", fl_a, 0);
    check("jmp_after_busy", busy_a, 0);
    check("jmp_perf", perf_a, 0);

    // Load into r0: suppressed only when R0_ZERO=1
    do_reset();
    dst_ex = 3'd0; rs_dec = 3'd0; use_rs_dec = 1; mem_read_ex = 1;
    #1;
    check("r0z_pc", pc_b, 1);
    check("r0z_bub", bub_b, 0);
    check("r0n_pc", pc_a, 0);
    tick();
    clr();

    // Reset during the second stalled cycle with MEM_LAT=4
    do_reset();
    load_hz();
    #1;
    check("rs_c0_pc", pc_c, 0);
    tick();
    clr();
    #1;
    check("rs_c1_busy", busy_c, 1);
    check("rs_c1_pc", pc_c, 0);
    rst = 1;
    #1;
    check("rs_now_pc", pc_c, 1);
    check("rs_now_fd", fd_c, 1);
    check("rs_now_bub", bub_c, 0);
    check("rs_now_flush", fl_c, 0);
    check("rs_now_busy", busy_c, 0);
    check("rs_now_perf", perf_c, 0);
    tick();
    rst = 0;
    #1;
    check("rs_rel_busy", busy_c, 0);
    check("rs_rel_pc", pc_c, 1);
    tick();
    check("rs_rel2_busy", busy_c, 0);
    check("rs_rel2_perf", perf_c, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
  AW, 3, register-address width.
  MEM_LAT, 1, load-use stall cycles (1..8).
  PC_LAT, 2, stall/flush cycles after a PC pop (1..8).
  R0_ZERO, 0, if 1 then a destination address of 0 never creates a hazard.
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
  clk  in  1  sole clock, rising edge.
  rst  in  1  asynchronous, active-high reset.
  rs_dec  in  AW  decode-stage source register.
  rd_dec  in  AW  decode-stage second source/destination register.
  use_rs_dec  in  1  rs_dec is read by the decode-stage instruction.
  use_rd_dec  in  1  rd_dec is read by the decode-stage instruction.
  jmp_dec, mem_write_dec, reg_write_dec, out_dec  in  1 each  decode-stage instruction class.
  dst_ex  in  AW  ALU-stage destination register.
  mem_read_ex, pop_ex, pop_flags_ex, pop_pc_ex  in  1 each  ALU-stage memory/pop class.
  jmp_taken_ex  in  1  ALU stage redirects the PC this cycle.
  pc_write_en  out  1  1 = PC may update.
  fd_write_en  out  1  1 = fetch/decode register may load.
  bubble_sel  out  1  1 = a NOP is inserted into decode/ALU.
  flush_fd  out  1  1 = the fetch/decode register is cleared.
  busy  out  1  FSM is not in IDLE.
  perf_stalls  out  16  count of cycles with pc_write_en=0.

Function
REQ-003 m(a) SHALL be (dst_ex==a) and not (R0_ZERO and dst_ex==0).
REQ-004 load_use SHALL be mem_read_ex & !pop_ex & ((m(rs_dec)&use_rs_dec) | (m(rd_dec)&use_rd_dec)).
REQ-005 pop_use SHALL be mem_read_ex & pop_ex & !pop_flags_ex & !pop_pc_ex & ((m(rd_dec)&(jmp_dec|reg_write_dec|out_dec)) | ((m(rs_dec)|m(rd_dec))&mem_write_dec)).
REQ-006 hazard SHALL be load_use | pop_use.
REQ-007 The FSM SHALL have exactly three states: IDLE, STALL, PCWAIT, with a down-counter cnt of width clog2(8)+1.
REQ-008 Event priority in IDLE SHALL be: pop_pc_ex > jmp_taken_ex > hazard.
REQ-009 IDLE with pop_pc_ex: in the same cycle pc_write_en=0, fd_write_en=0, flush_fd=1, bubble_sel=1; if PC_LAT>1, go to PCWAIT with cnt=PC_LAT-1.
REQ-010 PCWAIT SHALL drive the outputs of REQ-009 each cycle and decrement cnt; when cnt reaches 1 in PCWAIT, go to IDLE at the next edge.
REQ-011 IDLE with jmp_taken_ex and no pop_pc_ex: flush_fd=1 and bubble_sel=1 for that cycle only; PC and fd enables stay 1; hazard is ignored; state remains IDLE.
REQ-012 IDLE with hazard only: same-cycle pc_write_en=0, fd_write_en=0, bubble_sel=1, flush_fd=0; if MEM_LAT>1, go to STALL with cnt=MEM_LAT-1.
REQ-013 STALL SHALL hold the outputs of REQ-012, decrement cnt, and return to IDLE after cnt reaches 1, for a total of exactly MEM_LAT stalled cycles.
REQ-014 In STALL and PCWAIT, all hazard, jump and pop inputs SHALL be ignored.
REQ-015 In IDLE with no event: pc_write_en=1, fd_write_en=1, bubble_sel=0, flush_fd=0.
REQ-016 busy SHALL be 1 iff state is not IDLE.
REQ-017 perf_stalls SHALL increment on each clock edge where pc_write_en=0 and saturate at 16'hFFFF.
REQ-018 Outputs SHALL be combinational from state and inputs; the only registers SHALL be state, cnt and perf_stalls.

Reset
REQ-019 While rst=1: state=IDLE, cnt=0, perf_stalls=0, pc_write_en=1, fd_write_en=1, bubble_sel=0, flush_fd=0, busy=0, independent of all other inputs.
REQ-020 Reset asserted during STALL or PCWAIT SHALL abort the sequence immediately; the first cycle after release SHALL be IDLE.

Verification
REQ-021 MEM_LAT=3: dst_ex=2, rs_dec=2, use_rs_dec=1, mem_read_ex=1, pop_ex=0 -> pc_write_en=0 and bubble_sel=1 for 3 cycles, then 1/0; perf_stalls=3.
REQ-022 pop_ex=1, mem_read_ex=1, dst_ex=5, rd_dec=5, reg_write_dec=1, MEM_LAT=1 -> one-cycle stall; repeat with pop_flags_ex=1 -> no stall.
REQ-023 PC_LAT=2: pop_pc_ex=1 together with a load_use hazard -> flush_fd=1 and pc_write_en=0 for 2 cycles; STALL is never entered.
REQ-024 jmp_taken_ex=1 together with hazard -> flush_fd=1 for 1 cycle, pc_write_en stays 1, busy stays 0.
REQ-025 R0_ZERO=1, dst_ex=0, rs_dec=0, load -> no stall; with R0_ZERO=0 -> stall.
REQ-026 rst pulsed in the 2nd STALL cycle (MEM_LAT=4) -> outputs go to reset values immediately, perf_stalls=0, busy=0 after release.
